// File: rtl/mpu_pkg.sv
// mpu_pkg: constants, loader state type and element addressing shared by the
// MPU matrix loader and the operation units that consume its packed bus.
//   ELEM_BITS   - width of one signed matrix element
//   MAX_DIM     - largest supported matrix dimension
//   MATRIX_BITS - width of the packed matrix bus
//   elem_offset - bit offset of element (r,c) in the packed bus
package mpu_pkg;

    localparam int unsigned ELEM_BITS   = 8;
    localparam int unsigned MAX_DIM     = 5;
    localparam int unsigned MATRIX_BITS = ELEM_BITS * MAX_DIM * MAX_DIM;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone
    } loader_state_e;

    // Row-major placement on a bus declared [0:MATRIX_BITS-1]; (0,0) sits at [0:7].
    function automatic int unsigned elem_offset(input logic [2:0] r, input logic [2:0] c);
        return ELEM_BITS * ({29'd0, c} + MAX_DIM * {29'd0, r});
    endfunction

endpackage

// File: rtl/mpu_index_counter.sv
// mpu_index_counter: 3-bit row/col index pair walking a dim x dim matrix.
// Optional column-major ordering when MPU_LOADER_COLMAJOR_EN is defined.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   clear         - return both indices to zero (has priority over advance)
//   advance       - step to the next element
//   dim           - matrix dimension, 1..MAX_DIM
//   col_major     - (MPU_LOADER_COLMAJOR_EN only) row is the fast index
//   row, col      - current element indices
//   wrap          - the fast index is at dim-1
//   last          - current element is (dim-1, dim-1)
module mpu_index_counter
    import mpu_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    input  logic [2:0] dim,
`ifdef MPU_LOADER_COLMAJOR_EN
    input  logic       col_major,
`endif
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       wrap,
    output logic       last
);

    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic [2:0] dim_m1;
    logic [2:0] inner, outer;
    logic [2:0] inner_d, outer_d;

    assign dim_m1 = dim - 3'd1;

    // inner is the fast-moving index, outer steps when inner wraps.
`ifdef MPU_LOADER_COLMAJOR_EN
    assign inner = col_major ? row_q : col_q;
    assign outer = col_major ? col_q : row_q;
`else
    assign inner = col_q;
    assign outer = row_q;
`endif

    assign wrap = (inner == dim_m1);
    assign last = wrap && (outer == dim_m1);

    always_comb begin
        inner_d = inner;
        outer_d = outer;
        if (advance) begin
            if (last) begin
                inner_d = 3'd0;
                outer_d = 3'd0;
            end else if (wrap) begin
                inner_d = 3'd0;
                outer_d = outer + 3'd1;
            end else begin
                inner_d = inner + 3'd1;
            end
        end
`ifdef MPU_LOADER_COLMAJOR_EN
        row_d = col_major ? inner_d : outer_d;
        col_d = col_major ? outer_d : inner_d;
`else
        row_d = outer_d;
        col_d = inner_d;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            row_q <= 3'd0;
            col_q <= 3'd0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row = row_q;
    assign col = col_q;

endmodule

// File: rtl/mpu_matrix_loader.sv
// mpu_matrix_loader: accepts a dimension and a stream of signed 8-bit elements,
// assembles the packed matrix bus and presents it with a valid/ready handshake.
// Optional feature macro: MPU_LOADER_COLMAJOR_EN (adds col_major, transposed fill).
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   start, size_in      - load request and dimension, sampled only in IDLE
//   col_major           - (MPU_LOADER_COLMAJOR_EN only) latched with start
//   in_valid/in_ready   - element handshake, in_data is the signed element
//   out_valid/out_ready - finished-matrix handshake
//   matrix              - packed matrix, element (r,c) at [8*(c+5*r) +: 8]
//   size                - latched dimension
//   error               - one-cycle pulse after a start with an illegal size
module mpu_matrix_loader
    import mpu_pkg::*;
#(
    parameter int unsigned MAX_DIM = 5
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
`ifdef MPU_LOADER_COLMAJOR_EN
    input  logic                             col_major,
`endif
    input  logic [7:0]                       size_in,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [7:0]                in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [0:8*MAX_DIM*MAX_DIM-1]     matrix,
    output logic signed [7:0]                size,
    output logic                             error
);

    localparam int unsigned MatrixBits = 8 * MAX_DIM * MAX_DIM;
    localparam logic [7:0]  MaxDimByte = 8'(MAX_DIM);

    loader_state_e             state_q, state_d;
    logic [7:0]                size_q, size_d;
    logic [0:MatrixBits-1]     matrix_q, matrix_d;
    logic                      error_q, error_d;
    logic                      cnt_clear, cnt_advance;
    logic [2:0]                row, col;
    logic                      cnt_wrap, cnt_last;
    logic                      size_legal;
`ifdef MPU_LOADER_COLMAJOR_EN
    logic                      colmaj_q, colmaj_d;
`endif

    assign size_legal = (size_in != 8'd0) && (size_in <= MaxDimByte);

    mpu_index_counter u_index (
        .clock     (clock),
        .reset     (reset),
        .clear     (cnt_clear),
        .advance   (cnt_advance),
        .dim       (size_q[2:0]),
`ifdef MPU_LOADER_COLMAJOR_EN
        .col_major (colmaj_q),
`endif
        .row       (row),
        .col       (col),
        .wrap      (cnt_wrap),
        .last      (cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        matrix_d    = matrix_q;
        error_d     = 1'b0;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;
`ifdef MPU_LOADER_COLMAJOR_EN
        colmaj_d    = colmaj_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (size_legal) begin
                        size_d    = size_in;
                        matrix_d  = '0;
                        cnt_clear = 1'b1;
                        state_d   = StLoad;
`ifdef MPU_LOADER_COLMAJOR_EN
                        colmaj_d  = col_major;
`endif
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (in_valid) begin
                    matrix_d[elem_offset(row, col) +: ELEM_BITS] = in_data;
                    cnt_advance = 1'b1;
                    // last implies wrap of the fast index; both must hold on the final beat
                    if (cnt_wrap && cnt_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            size_q   <= 8'd0;
            matrix_q <= '0;
            error_q  <= 1'b0;
`ifdef MPU_LOADER_COLMAJOR_EN
            colmaj_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            matrix_q <= matrix_d;
            error_q  <= error_d;
`ifdef MPU_LOADER_COLMAJOR_EN
            colmaj_q <= colmaj_d;
`endif
        end
    end

    assign in_ready  = (state_q == StLoad);
    assign out_valid = (state_q == StDone);
    assign matrix    = matrix_q;
    assign size      = size_q;
    assign error     = error_q;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
module tb_mpu_matrix_loader;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              col_major;
    logic [7:0]        size_in;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [0:199]      matrix;
    logic signed [7:0] size;
    logic              error;

    always #5 clock = ~clock;

    mpu_matrix_loader #(
        .MAX_DIM (5)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
`ifdef MPU_LOADER_COLMAJOR_EN
        .col_major (col_major),
`endif
        .size_in   (size_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .matrix    (matrix),
        .size      (size),
        .error     (error)
    );

    typedef struct {
        logic [0:199] m;
        logic [7:0]   sz;
    } sb_item_t;

    sb_item_t          sb[$];
    sb_item_t          mon_it;
    int                checks = 0;
    int                errors = 0;
    logic signed [7:0] stream [25];
    logic [0:199]      last_m;
    logic [7:0]        last_sz;
    logic [0:199]      mt;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Scoreboard side: every completed handshake pops one expected matrix.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_pop", 256'(sb.size()), 256'(1));
            end else begin
                mon_it = sb.pop_front();
                check_eq("sb_matrix", 256'(matrix), 256'(mon_it.m));
                check_eq("sb_size", 256'(size), 256'(mon_it.sz));
            end
        end
    end

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        sb.delete();
        last_m  = '0;
        last_sz = 8'd0;
    endtask

    // Full load of stream[0..n*n-1]; gap stalls every third cycle, early holds
    // out_ready high from the start, hold keeps out_ready low in DONE.
    task automatic run_load(input int n, input bit colm, input bit gap, input int hold,
                            input bit early);
        sb_item_t it;
        int k, g, cyc, stalls, r, c;
        it.m  = '0;
        it.sz = 8'(n);
        for (int i = 0; i < n * n; i++) begin
            r = colm ? (i % n) : (i / n);
            c = colm ? (i / n) : (i % n);
            it.m[8 * (c + 5 * r) +: 8] = stream[i];
        end
        sb.push_back(it);
        start     = 1'b1;
        size_in   = 8'(n);
        col_major = colm;
        out_ready = early;
        tick;
        start = 1'b0;
        cyc   = 1;
        check_eq("start_ready", 256'(in_ready), 256'(1));
        check_eq("start_noerr", 256'(error), 256'(0));
        k = 0;
        g = 0;
        stalls = 0;
        while (k < n * n && g < 200) begin
            if (gap && (g % 3 == 2)) begin
                in_valid = 1'b0;
                stalls++;
            end else begin
                check_eq("beat_ready", 256'(in_ready), 256'(1));
                in_valid = 1'b1;
                in_data  = stream[k];
                k++;
            end
            tick;
            cyc++;
            g++;
        end
        in_valid = 1'b0;
        check_eq("done_valid", 256'(out_valid), 256'(1));
        check_eq("done_latency", 256'(cyc), 256'(1 + n * n + stalls));
        check_eq("done_ready", 256'(in_ready), 256'(0));
        check_eq("done_matrix", 256'(matrix), 256'(it.m));
        for (int h = 0; h < hold; h++) begin
            tick;
            check_eq("hold_valid", 256'(out_valid), 256'(1));
            check_eq("hold_matrix", 256'(matrix), 256'(it.m));
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check_eq("post_valid", 256'(out_valid), 256'(0));
        check_eq("post_matrix", 256'(matrix), 256'(it.m));
        check_eq("post_size", 256'(size), 256'(it.sz));
        last_m  = it.m;
        last_sz = it.sz;
    endtask

    task automatic bad_start(input logic [7:0] s);
        start   = 1'b1;
        size_in = s;
        tick;
        start = 1'b0;
        check_eq("err_pulse", 256'(error), 256'(1));
        check_eq("err_ready", 256'(in_ready), 256'(0));
        tick;
        check_eq("err_clear", 256'(error), 256'(0));
        check_eq("err_idle", 256'(in_ready), 256'(0));
        check_eq("err_matrix", 256'(matrix), 256'(last_m));
        check_eq("err_size", 256'(size), 256'(last_sz));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        start     = 1'b0;
        col_major = 1'b0;
        size_in   = 8'd0;
        in_valid  = 1'b0;
        in_data   = 8'sd0;
        out_ready = 1'b0;
        do_reset;
        check_eq("rst_ready", 256'(in_ready), 256'(0));
        check_eq("rst_valid", 256'(out_valid), 256'(0));
        check_eq("rst_error", 256'(error), 256'(0));
        check_eq("rst_matrix", 256'(matrix), 256'(0));
        check_eq("rst_size", 256'(size), 256'(0));

        // Size 2, continuous 1..4
        for (int i = 0; i < 4; i++) stream[i] = 8'(i + 1);
        run_load(2, 1'b0, 1'b0, 0, 1'b0);
        mt = matrix;
        check_eq("s2_b00", 256'(mt[0:7]), 256'(1));
        check_eq("s2_b01", 256'(mt[8:15]), 256'(2));
        check_eq("s2_b10", 256'(mt[40:47]), 256'(3));
        check_eq("s2_b11", 256'(mt[48:55]), 256'(4));
        tick;

        // Size 5, -1..-25 with stalls, out_ready held high before DONE
        for (int i = 0; i < 25; i++) stream[i] = 8'(-(i + 1));
        run_load(5, 1'b0, 1'b1, 0, 1'b1);
        mt = matrix;
        check_eq("s5_b44", 256'(mt[192:199]), 256'(8'hE7));
        check_eq("s5_b00", 256'(mt[0:7]), 256'(8'hFF));
        tick;

        bad_start(8'd0);
        bad_start(8'd6);
        bad_start(8'd200);

        // Size 3 random, long hold, then a back-to-back size-1 load
        for (int i = 0; i < 9; i++) stream[i] = 8'($urandom_range(0, 255));
        run_load(3, 1'b0, 1'b0, 10, 1'b0);
        stream[0] = 8'sd7;
        run_load(1, 1'b0, 1'b0, 0, 1'b0);
        tick;

        // Size 4 aborted by reset after 7 beats
        start   = 1'b1;
        size_in = 8'd4;
        tick;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + 10);
            tick;
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick;
        check_eq("abort_matrix", 256'(matrix), 256'(0));
        check_eq("abort_size", 256'(size), 256'(0));
        check_eq("abort_ready", 256'(in_ready), 256'(0));
        check_eq("abort_valid", 256'(out_valid), 256'(0));
        reset = 1'b0;
        sb.delete();
        last_m  = '0;
        last_sz = 8'd0;
        tick;
        stream[0] = 8'sd42;
        run_load(1, 1'b0, 1'b0, 0, 1'b0);
        mt = matrix;
        check_eq("s1_b00", 256'(mt[0:7]), 256'(42));
        tick;

`ifdef MPU_LOADER_COLMAJOR_EN
        for (int i = 0; i < 4; i++) stream[i] = 8'(i + 1);
        run_load(2, 1'b1, 1'b0, 0, 1'b0);
        mt = matrix;
        check_eq("cm_b00", 256'(mt[0:7]), 256'(1));
        check_eq("cm_b10", 256'(mt[40:47]), 256'(2));
        check_eq("cm_b01", 256'(mt[8:15]), 256'(3));
        check_eq("cm_b11", 256'(mt[48:55]), 256'(4));
        tick;
        for (int i = 0; i < 9; i++) stream[i] = 8'($urandom_range(0, 255));
        run_load(3, 1'b1, 1'b1, 2, 1'b0);
        tick;
`endif

        tick;
        check_eq("sb_empty", 256'(sb.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
